// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, event layout and helpers for the keypad scanner
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int EVT_W      = 5;
  localparam int FIFO_DEPTH = 4;

  // Event word layout: {code[3:0], press}
  localparam int EVT_PRESS_BIT = 0;
  localparam int EVT_CODE_LSB  = 1;

  // Scanner FSM encoding
  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  typedef logic [EVT_W-1:0] evt_t;

  // Active-low one-hot column drive for column c
  function automatic logic [3:0] col_drive_n(input logic [1:0] c);
    col_drive_n = ~(4'b0001 << c);
  endfunction

  // Pack a key code and press flag into an event word
  function automatic evt_t pack_event(input logic [KEY_CODE_W-1:0] code, input logic press);
    evt_t e;
    e = '0;
    e[EVT_CODE_LSB +: KEY_CODE_W] = code;
    e[EVT_PRESS_BIT] = press;
    pack_event = e;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - 4-entry show-ahead event queue with full/empty/drop flags
module key_event_fifo
  import keypad_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty,
  output logic drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged on start-of-cycle occupancy, so a simultaneous pop
  // never rescues a push into a full queue.
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign drop    = push && full;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with per-key debounce and event queue
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int pSettleCycles = 1000,
  parameter int pSampleScans  = 4
) (
  input  logic        iwClk,
  input  logic        iwRst,
  output logic [3:0]  orColN,
  input  logic [3:0]  iwRowN,
  output logic        orEvtValid,
  output logic [3:0]  owEvtCode,
  output logic        owEvtPress,
  input  logic        iwEvtReady,
  output logic        orOverflow,
  input  logic        iwOverflowClr,
  output logic [15:0] owKeyState
);

  localparam int SETTLE_W = $clog2(pSettleCycles);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST   = SETTLE_W'(pSettleCycles - 1);
  localparam logic [3:0]          SAMPLE_TARGET = 4'(pSampleScans);

  logic [3:0]          row_meta;
  logic [3:0]          row_sync;
  logic [3:0]          sample;
  logic [0:0]          state;
  logic [1:0]          col;
  logic [1:0]          row_idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [3:0]          key_cnt [16];
  logic [15:0]         key_state;

  logic [3:0] key_idx;
  logic       raw;
  logic [3:0] cnt_next;
  logic       differ;
  logic       in_update;
  logic       evt_push;
  evt_t       evt_data;
  evt_t       fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_drop;
  logic       unused_fifo_full;

  // Current key under evaluation: code = row*4 + col
  assign key_idx   = {row_idx, col};
  assign raw       = ~sample[row_idx];
  assign cnt_next  = key_cnt[key_idx] + 4'd1;
  assign differ    = (raw != key_state[key_idx]);
  assign in_update = (state == ST_UPDATE);
  assign evt_push  = in_update && differ && (cnt_next == SAMPLE_TARGET);
  assign evt_data  = pack_event(key_idx, raw);

  // Drop already captures the full-while-pushing case
  assign unused_fifo_full = fifo_full;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= iwRowN;
      row_sync <= row_meta;
    end
  end

  // Column sequencer: settle, sample all rows, then walk the four rows
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      state      <= ST_SETTLE;
      col        <= 2'd0;
      row_idx    <= 2'd0;
      settle_cnt <= '0;
      sample     <= 4'hF;
      orColN     <= col_drive_n(2'd0);
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            sample     <= row_sync;
            settle_cnt <= '0;
            row_idx    <= 2'd0;
            state      <= ST_UPDATE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: begin
          if (row_idx == 2'd3) begin
            col    <= col + 2'd1;
            orColN <= col_drive_n(col + 2'd1);
            state  <= ST_SETTLE;
          end else begin
            row_idx <= row_idx + 2'd1;
          end
        end
      endcase
    end
  end

  // Per-key debounce: a run of disagreeing scans flips the debounced state
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      for (int k = 0; k < 16; k++) begin
        key_cnt[k] <= 4'd0;
      end
      key_state <= 16'h0000;
    end else if (in_update) begin
      if (!differ) begin
        key_cnt[key_idx] <= 4'd0;
      end else if (cnt_next == SAMPLE_TARGET) begin
        key_state[key_idx] <= raw;
        key_cnt[key_idx]   <= 4'd0;
      end else begin
        key_cnt[key_idx] <= cnt_next;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle wins over clear
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      orOverflow <= 1'b0;
    end else if (fifo_drop) begin
      orOverflow <= 1'b1;
    end else if (iwOverflowClr) begin
      orOverflow <= 1'b0;
    end
  end

  key_event_fifo u_fifo (
    .clk       (iwClk),
    .rst       (iwRst),
    .push      (evt_push),
    .push_data (evt_data),
    .pop       (iwEvtReady),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign orEvtValid = !fifo_empty;
  assign owEvtCode  = fifo_head[EVT_CODE_LSB +: KEY_CODE_W];
  assign owEvtPress = fifo_head[EVT_PRESS_BIT];
  assign owKeyState = key_state;

endmodule
